sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of a single SDRAM controller port.
// Serves periodic refresh ahead of port traffic, round-robins between the two ports, and
// returns read data on a one-cycle ack pulse. All state is registered; reset is synchronous.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W           = 24,
    parameter int unsigned REFRESH_INTERVAL = 975
) (
    input  logic              clk,
    input  logic              reset_in,

    // Port 0
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [15:0]       p0_wdata,
    input  logic [1:0]        p0_bytesel,
    output logic [15:0]       p0_rdata,
    output logic              p0_ack,

    // Port 1
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_wdata,
    input  logic [1:0]        p1_bytesel,
    output logic [15:0]       p1_rdata,
    output logic              p1_ack,

    // Controller command port
    output logic              ctl_req,
    output logic              ctl_wr,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [15:0]       ctl_wdata,
    output logic [1:0]        ctl_bytesel,
    input  logic [15:0]       ctl_rdata,
    input  logic              ctl_ack,

    // Controller refresh handshake
    output logic              ctl_refresh,
    input  logic              ctl_refresh_ack
);

    localparam int unsigned    CntW    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(REFRESH_INTERVAL - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant0,
        StGrant1,
        StRefresh,
        StDone0,
        StDone1
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] refresh_cnt_q;
    logic [1:0]      pending_q;
    logic            last_grant_q;   // port granted most recently; 1 after reset so p0 goes first

    logic            expire;
    logic            refresh_done;
    logic            grant_p1;

    // Counter reaching zero marks one elapsed refresh interval
    assign expire       = (refresh_cnt_q == '0);
    // Only a refresh ack seen while in REFRESH retires a pending refresh
    assign refresh_done = (state_q == StRefresh) && ctl_refresh_ack;
    // With both ports requesting, favour the one not served last
    assign grant_p1     = p1_req && (!p0_req || !last_grant_q);

    // Free-running refresh interval counter, reloaded on expiry
    always_ff @(posedge clk) begin
        if (reset_in || expire) begin
            refresh_cnt_q <= CntLoad;
        end else begin
            refresh_cnt_q <= refresh_cnt_q - CntW'(1);
        end
    end

    // Pending refresh count: +1 on expiry (saturating at 3), -1 when a refresh completes;
    // an expiry landing on the completing edge cancels out and leaves the count as is
    always_ff @(posedge clk) begin
        if (reset_in) begin
            pending_q <= 2'd0;
        end else if (refresh_done) begin
            if (!expire) begin
                pending_q <= pending_q - 2'd1;
            end
        end else if (expire && (pending_q != 2'd3)) begin
            pending_q <= pending_q + 2'd1;
        end
    end

    // Arbitration FSM with registered controller command and port responses
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            ctl_req      <= 1'b0;
            ctl_refresh  <= 1'b0;
            ctl_wr       <= 1'b0;
            ctl_addr     <= '0;
            ctl_wdata    <= '0;
            ctl_bytesel  <= '0;
            p0_ack       <= 1'b0;
            p1_ack       <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
        end else begin
            // Acks are single-cycle pulses; only a completing grant raises one
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (pending_q != 2'd0) begin
                        ctl_refresh <= 1'b1;
                        state_q     <= StRefresh;
                    end else if (grant_p1) begin
                        ctl_req     <= 1'b1;
                        ctl_wr      <= p1_wr;
                        ctl_addr    <= p1_addr;
                        ctl_wdata   <= p1_wdata;
                        ctl_bytesel <= p1_bytesel;
                        state_q     <= StGrant1;
                    end else if (p0_req) begin
                        ctl_req     <= 1'b1;
                        ctl_wr      <= p0_wr;
                        ctl_addr    <= p0_addr;
                        ctl_wdata   <= p0_wdata;
                        ctl_bytesel <= p0_bytesel;
                        state_q     <= StGrant0;
                    end
                end

                StGrant0: begin
                    if (ctl_ack) begin
                        ctl_req      <= 1'b0;
                        p0_rdata     <= ctl_rdata;
                        p0_ack       <= 1'b1;
                        last_grant_q <= 1'b0;
                        state_q      <= StDone0;
                    end
                end

                StGrant1: begin
                    if (ctl_ack) begin
                        ctl_req      <= 1'b0;
                        p1_rdata     <= ctl_rdata;
                        p1_ack       <= 1'b1;
                        last_grant_q <= 1'b1;
                        state_q      <= StDone1;
                    end
                end

                StRefresh: begin
                    if (ctl_refresh_ack) begin
                        ctl_refresh <= 1'b0;
                        state_q     <= StIdle;
                    end
                end

                // Requester drops req while the ack is visible, so req is not sampled here
                StDone0, StDone1: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Structural invariants of the controller handshake
    a_req_refresh_excl: assert property (@(posedge clk) disable iff (reset_in)
        !(ctl_req && ctl_refresh));

    a_single_ack: assert property (@(posedge clk) disable iff (reset_in)
        !(p0_ack && p1_ack));

    a_cmd_stable: assert property (@(posedge clk) disable iff (reset_in)
        (ctl_req && !ctl_ack) |=> ($stable(ctl_addr) && $stable(ctl_wr) &&
                                   $stable(ctl_wdata) && $stable(ctl_bytesel)));

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: drivers push expected grants/acks into queues,
// a negedge monitor pops and compares whenever the DUT raises ctl_req or a port ack.
module tb_sdram_port_arbiter;

    localparam int unsigned AW = 24;
    localparam int unsigned RI = 16;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          p0_req, p0_wr, p1_req, p1_wr;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [15:0]   p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic [1:0]    p0_bytesel, p1_bytesel;
    logic          p0_ack, p1_ack;
    logic          ctl_req, ctl_wr, ctl_ack, ctl_refresh, ctl_refresh_ack;
    logic [AW-1:0] ctl_addr;
    logic [15:0]   ctl_wdata, ctl_rdata;
    logic [1:0]    ctl_bytesel;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W          (AW),
        .REFRESH_INTERVAL(RI)
    ) dut (
        .clk            (clk),
        .reset_in       (reset_in),
        .p0_req         (p0_req),
        .p0_wr          (p0_wr),
        .p0_addr        (p0_addr),
        .p0_wdata       (p0_wdata),
        .p0_bytesel     (p0_bytesel),
        .p0_rdata       (p0_rdata),
        .p0_ack         (p0_ack),
        .p1_req         (p1_req),
        .p1_wr          (p1_wr),
        .p1_addr        (p1_addr),
        .p1_wdata       (p1_wdata),
        .p1_bytesel     (p1_bytesel),
        .p1_rdata       (p1_rdata),
        .p1_ack         (p1_ack),
        .ctl_req        (ctl_req),
        .ctl_wr         (ctl_wr),
        .ctl_addr       (ctl_addr),
        .ctl_wdata      (ctl_wdata),
        .ctl_bytesel    (ctl_bytesel),
        .ctl_rdata      (ctl_rdata),
        .ctl_ack        (ctl_ack),
        .ctl_refresh    (ctl_refresh),
        .ctl_refresh_ack(ctl_refresh_ack)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [1:0]    bsel;
    } cmd_t;

    typedef struct {
        bit          port;
        bit          chk;
        logic [15:0] rdata;
    } ack_t;

    cmd_t exp_cmd[$];
    ack_t exp_ack[$];
    int   ref_rises[$];
    int   ref_falls[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int ack_delay = 4;
    int ref_delay = 3;
    bit mon_en    = 1'b0;
    int rel;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Controller read-data model
    function automatic logic [15:0] rdata_for(input logic [AW-1:0] a);
        if (a == 24'h000123) return 16'hBEEF;
        return a[15:0] ^ 16'h3C3C;
    endfunction

    // Controller access responder: ack ack_delay cycles after ctl_req is first seen
    initial begin
        ctl_ack   = 1'b0;
        ctl_rdata = '0;
        forever begin
            @(negedge clk);
            if (ctl_req === 1'b1) begin
                int d;
                d = ack_delay;
                repeat (d - 1) @(negedge clk);
                ctl_rdata = rdata_for(ctl_addr);
                ctl_ack   = 1'b1;
                @(negedge clk);
                ctl_ack   = 1'b0;
            end
        end
    end

    // Controller refresh responder
    initial begin
        ctl_refresh_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ctl_refresh === 1'b1) begin
                int d;
                d = ref_delay;
                repeat (d - 1) @(negedge clk);
                ctl_refresh_ack = 1'b1;
                @(negedge clk);
                ctl_refresh_ack = 1'b0;
            end
        end
    end

    task automatic mon_ack(input bit port, input logic ack, input logic prev, input logic [15:0] rd);
        if (ack === 1'b1) begin
            check_eq(port ? "p1_ack_pulse" : "p0_ack_pulse", prev, 0);
            check_eq(port ? "p1_ack_expected" : "p0_ack_expected", exp_ack.size() != 0, 1);
            if (exp_ack.size() != 0) begin
                ack_t e;
                e = exp_ack.pop_front();
                check_eq("ack_port", port, e.port);
                if (e.chk) check_eq(port ? "p1_rdata" : "p0_rdata", rd, e.rdata);
            end
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic prev_req, prev_ref, prev_a0, prev_a1;
        cmd_t prev_cmd, cur;
        prev_req = 0; prev_ref = 0; prev_a0 = 0; prev_a1 = 0;
        prev_cmd = '{1'b0, '0, '0, '0};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = '{ctl_wr, ctl_addr, ctl_wdata, ctl_bytesel};
                check_eq("req_refresh_exclusive", ctl_req & ctl_refresh, 0);
                check_eq("single_port_ack", p0_ack & p1_ack, 0);
                if (ctl_req === 1'b1 && !prev_req) begin
                    check_eq("grant_expected", exp_cmd.size() != 0, 1);
                    if (exp_cmd.size() != 0) begin
                        cmd_t e;
                        e = exp_cmd.pop_front();
                        check_eq("grant_wr", cur.wr, e.wr);
                        check_eq("grant_addr", cur.addr, e.addr);
                        check_eq("grant_wdata", cur.wdata, e.wdata);
                        check_eq("grant_bytesel", cur.bsel, e.bsel);
                    end
                end
                if (ctl_req === 1'b1 && prev_req)
                    check_eq("cmd_stable", {cur.wr, cur.addr, cur.wdata, cur.bsel},
                             {prev_cmd.wr, prev_cmd.addr, prev_cmd.wdata, prev_cmd.bsel});
                mon_ack(1'b0, p0_ack, prev_a0, p0_rdata);
                mon_ack(1'b1, p1_ack, prev_a1, p1_rdata);
                if (ctl_refresh === 1'b1 && !prev_ref) ref_rises.push_back(cyc);
                if (ctl_refresh === 1'b0 && prev_ref) ref_falls.push_back(cyc);
                prev_req = (ctl_req === 1'b1);
                prev_ref = (ctl_refresh === 1'b1);
                prev_a0  = (p0_ack === 1'b1);
                prev_a1  = (p1_ack === 1'b1);
                prev_cmd = cur;
            end
        end
    end

    task automatic expect_txn(input bit port, input logic wr, input logic [AW-1:0] addr,
                              input logic [15:0] wd, input logic [1:0] bs, input bit chk,
                              input logic [15:0] rd);
        exp_cmd.push_back('{wr, addr, wd, bs});
        exp_ack.push_back('{port, chk, rd});
    endtask

    // Called on a negedge; returns on the negedge where the ack is visible, req dropped
    task automatic do_access(input bit port, input logic wr, input logic [AW-1:0] addr,
                             input logic [15:0] wd, input logic [1:0] bs, output int ack_cyc);
        bit got;
        got = 1'b0;
        if (port) begin
            p1_wr = wr; p1_addr = addr; p1_wdata = wd; p1_bytesel = bs; p1_req = 1'b1;
        end else begin
            p0_wr = wr; p0_addr = addr; p0_wdata = wd; p0_bytesel = bs; p0_req = 1'b1;
        end
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if ((port ? p1_ack : p0_ack) === 1'b1) got = 1'b1;
        end
        ack_cyc = cyc;
        if (port) p1_req = 1'b0;
        else      p0_req = 1'b0;
        check_eq(port ? "p1_ack_arrived" : "p0_ack_arrived", got, 1);
    endtask

    task automatic apply_reset();
        p0_req = 0; p1_req = 0;
        reset_in = 1'b1;
        repeat (3) @(negedge clk);
        reset_in = 1'b0;
        rel = cyc;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ctl_req"}, ctl_req, 0);
        check_eq({tag, "_ctl_refresh"}, ctl_refresh, 0);
        check_eq({tag, "_p0_ack"}, p0_ack, 0);
        check_eq({tag, "_p1_ack"}, p1_ack, 0);
        check_eq({tag, "_ctl_cmd"}, {ctl_wr, ctl_addr, ctl_wdata, ctl_bytesel}, 0);
        check_eq({tag, "_p0_rdata"}, p0_rdata, 0);
        check_eq({tag, "_p1_rdata"}, p1_rdata, 0);
    endtask

    initial begin
        int a;
        reset_in = 1'b1;
        p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0; p0_bytesel = '0;
        p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0; p1_bytesel = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        check_zero("reset_state");

        // Single read on port 0, controller acks 4 cycles after grant
        apply_reset();
        ack_delay = 4;
        expect_txn(1'b0, 1'b0, 24'h000123, 16'h0000, 2'b11, 1'b1, 16'hBEEF);
        do_access(1'b0, 1'b0, 24'h000123, 16'h0000, 2'b11, a);
        check_eq("p0_read_latency", a - rel, 5);
        repeat (4) @(negedge clk);

        // Port 1 write, fields held until ack
        apply_reset();
        ack_delay = 5;
        expect_txn(1'b1, 1'b1, 24'h00ABCD, 16'h5A5A, 2'b10, 1'b0, 16'h0000);
        do_access(1'b1, 1'b1, 24'h00ABCD, 16'h5A5A, 2'b10, a);
        check_eq("p1_write_latency", a - rel, 6);
        repeat (4) @(negedge clk);

        // Contention: both ports request together and re-request; expect p0,p1,p0,p1
        apply_reset();
        ack_delay = 2;
        expect_txn(1'b0, 1'b0, 24'h000010, 16'h1111, 2'b11, 1'b1, 16'h3C2C);
        expect_txn(1'b1, 1'b0, 24'h000020, 16'h2222, 2'b11, 1'b1, 16'h3C1C);
        expect_txn(1'b0, 1'b0, 24'h000030, 16'h3333, 2'b01, 1'b1, 16'h3C0C);
        expect_txn(1'b1, 1'b0, 24'h000040, 16'h4444, 2'b10, 1'b1, 16'h3C7C);
        fork
            begin
                int t0;
                do_access(1'b0, 1'b0, 24'h000010, 16'h1111, 2'b11, t0);
                @(negedge clk);
                do_access(1'b0, 1'b0, 24'h000030, 16'h3333, 2'b01, t0);
            end
            begin
                int t1;
                do_access(1'b1, 1'b0, 24'h000020, 16'h2222, 2'b11, t1);
                @(negedge clk);
                do_access(1'b1, 1'b0, 24'h000040, 16'h4444, 2'b10, t1);
            end
        join
        repeat (6) @(negedge clk);

        // Refresh cadence with no traffic
        apply_reset();
        ref_delay = 3;
        ref_rises.delete();
        ref_falls.delete();
        repeat (55) @(negedge clk);
        check_eq("refresh_rise_count", ref_rises.size() >= 3, 1);
        check_eq("refresh_fall_count", ref_falls.size() >= 1, 1);
        if (ref_rises.size() >= 3) begin
            check_eq("refresh_first_rise", ref_rises[0] - rel, 17);
            check_eq("refresh_period_1", ref_rises[1] - ref_rises[0], 16);
            check_eq("refresh_period_2", ref_rises[2] - ref_rises[1], 16);
        end
        if (ref_falls.size() >= 1 && ref_rises.size() >= 1)
            check_eq("refresh_ack_return", ref_falls[0] - ref_rises[0], 3);

        // Refresh expiring twice during a long p1 access: two back-to-back refreshes follow
        apply_reset();
        ack_delay = 40;
        ref_rises.delete();
        expect_txn(1'b1, 1'b0, 24'h000456, 16'h0000, 2'b11, 1'b1, 16'h386A);
        do_access(1'b1, 1'b0, 24'h000456, 16'h0000, 2'b11, a);
        check_eq("p1_long_latency", a - rel, 41);
        repeat (12) @(negedge clk);
        check_eq("deferred_refresh_count", ref_rises.size() >= 2, 1);
        if (ref_rises.size() >= 2) begin
            check_eq("deferred_refresh_1", ref_rises[0] - a, 2);
            check_eq("deferred_refresh_2", ref_rises[1] - a, 6);
        end
        repeat (20) @(negedge clk);

        // Reset mid-GRANT0, stray ctl_ack afterwards, then a normal p1 read
        apply_reset();
        ack_delay = 6;
        exp_cmd.push_back('{1'b0, 24'h0000AA, 16'h0000, 2'b11});
        p0_wr = 1'b0; p0_addr = 24'h0000AA; p0_wdata = '0; p0_bytesel = 2'b11; p0_req = 1'b1;
        repeat (3) @(negedge clk);
        apply_reset();
        @(negedge clk);
        check_zero("after_abort");
        ack_delay = 3;
        expect_txn(1'b1, 1'b0, 24'h000077, 16'h0000, 2'b11, 1'b1, 16'h3C4B);
        do_access(1'b1, 1'b0, 24'h000077, 16'h0000, 2'b11, a);
        check_eq("p1_after_abort_latency", a - rel, 5);
        repeat (6) @(negedge clk);

        check_eq("cmd_queue_drained", exp_cmd.size(), 0);
        check_eq("ack_queue_drained", exp_ack.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
